pool_sched: RTL
===============

Name: pool_sched

Overview:
- Scheduler and controller for the SIMD processor pool.
- Accepts a single instruction stream and dispatches each instruction to a free processor over that processor's valid/ack handshake.
- Round-robin arbitrates the processors' shared-resource requests (req/grant), gates processor enables from a config mask, and tracks in-flight work.
- Sits between the command front end and the pool instance.

Parameters:
- N_PROC, `PROC_COUNT: number of processors served.
- IDX_W, $clog2(N_PROC) (min 1): processor index width.
- ACK_TIMEOUT, 64: cycles to wait for a dispatch ack before aborting.
- CNT_W, 8: in-flight counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_instr  in  instr_t  instruction to dispatch.
- i_instr_valid  in  1  i_instr valid.
- o_instr_ready  out  1  scheduler accepts i_instr this cycle.
- i_proc_mask  in  N_PROC  1 = processor disabled (config).
- o_pool_instr  out  instr_t [N_PROC]  per-processor instruction.
- o_pool_en  out  N_PROC  processor enable.
- o_pool_valid  out  N_PROC  dispatch valid.
- o_pool_grant  out  N_PROC  one-hot resource grant.
- i_pool_req  in  N_PROC  resource request.
- i_pool_ack  in  N_PROC  dispatch accepted.
- i_pool_busy  in  N_PROC  processor busy.
- i_pool_finish  in  N_PROC  completion pulse.
- o_done  out  N_PROC  registered copy of i_pool_finish.
- o_inflight  out  CNT_W  instructions acked but not yet finished.
- o_idle  out  1  nothing in flight and dispatcher idle.
- o_err  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset: every output 0, except o_idle = 1. o_pool_instr = 0. FSM in IDLE, RR pointer = 0, timeout counter = 0, in-flight = 0. A reset mid-dispatch or mid-grant drops valid/grant the next cycle, with no ack/err.
- free[k] = ~i_pool_busy[k] & ~i_proc_mask[k] & ~i_pool_ack[k].
- o_pool_en = ~i_proc_mask (registered, 1-cycle latency).
- Dispatch FSM:
  - IDLE: o_instr_ready = |free (combinational). On i_instr_valid & o_instr_ready: target k = lowest free index; latch i_instr into o_pool_instr[k]; go to ISSUE.
  - ISSUE: o_pool_valid[k] = 1, o_instr_ready = 0, timeout counter increments.
    - i_pool_ack[k] = 1: valid drops next cycle, in-flight +1, go to IDLE. The next accept is possible 1 cycle later, so peak throughput is 1 instr per 2 cycles when ack is same-cycle.
    - Counter reaches ACK_TIMEOUT-1 without ack: o_err pulses, valid drops, go to IDLE. The instruction is discarded.
  - Ack on a non-target processor is ignored.
  - Mask change on the target during ISSUE does not abort; it takes effect on the next selection.
- Arbiter:
  - Grant is registered and one-hot.
  - The holder keeps the grant while its req stays high (locked, no preemption).
  - When the holder drops req, or nothing is granted: the next grant goes to the first requester searching from (last holder + 1) mod N_PROC, wrapping. It appears the cycle after the req change.
  - No requester: grant = 0.
  - Masked processors are never granted. Masking the current holder drops its grant next cycle.
- In-flight counter: +1 on dispatch ack, minus popcount(i_pool_finish) in the same cycle (net update).
  - Saturates at 2^CNT_W-1.
  - Never goes below 0; a finish at 0 is ignored.
- o_done = i_pool_finish delayed 1 cycle.
- o_idle = (in-flight == 0) & (FSM == IDLE), registered.

Test Plan:
- Reset, then N_PROC=4, all free: send instr A with valid=1 -> ready=1; next cycle o_pool_valid=4'b0001, o_pool_instr[0]=A; ack[0] -> valid 0 next cycle, o_inflight=1, o_idle=0.
- busy=4'b0011, mask=4'b0100: send B -> dispatched to proc 3. busy=4'b1011 with mask=4'b0100 -> ready=0, no accept.
- Withhold ack with ACK_TIMEOUT=64 -> valid held exactly 64 cycles, then o_err=1 for 1 cycle, FSM back to IDLE, o_inflight unchanged.
- req=4'b1111 held, each holder releases after 2 cycles -> grants 0,1,2,3,0 in order, always one-hot. Holder 1 keeps req high for 10 cycles -> grant stays 4'b0010 for all 10.
- in-flight=3, finish=4'b0101 in the same cycle as a dispatch ack -> o_inflight=2, o_done=4'b0101 one cycle later. Finish at in-flight=0 -> stays 0.
- Assert i_rst during ISSUE with grant active -> next cycle valid=0, grant=0, o_idle=1, o_inflight=0, FSM in IDLE.

Source files
------------

// File: rtl/pool_sched.sv
// pool_sched: dispatches one instruction stream onto a pool of SIMD processors,
// round-robin arbitrates their shared-resource requests, gates processor
// enables from a config mask and tracks instructions in flight.
`timescale 1ns/1ps

`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package pool_sched_pkg;
    // Instruction word carried from the command front end to a processor.
    typedef logic [31:0] instr_t;
endpackage

module pool_sched
    import pool_sched_pkg::*;
#(
    parameter int N_PROC      = `PROC_COUNT,
    parameter int IDX_W       = (N_PROC > 1) ? $clog2(N_PROC) : 1,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  instr_t               i_instr,
    input  logic                 i_instr_valid,
    output logic                 o_instr_ready,
    input  logic [N_PROC-1:0]    i_proc_mask,
    output instr_t [N_PROC-1:0]  o_pool_instr,
    output logic [N_PROC-1:0]    o_pool_en,
    output logic [N_PROC-1:0]    o_pool_valid,
    output logic [N_PROC-1:0]    o_pool_grant,
    input  logic [N_PROC-1:0]    i_pool_req,
    input  logic [N_PROC-1:0]    i_pool_ack,
    input  logic [N_PROC-1:0]    i_pool_busy,
    input  logic [N_PROC-1:0]    i_pool_finish,
    output logic [N_PROC-1:0]    o_done,
    output logic [CNT_W-1:0]     o_inflight,
    output logic                 o_idle,
    output logic                 o_err
);
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    // Wide enough for in-flight + 1 and for a popcount of all finish bits.
    localparam int SUM_W = CNT_W + IDX_W + 2;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [SUM_W-1:0] CNT_MAX  = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  tgt;
    logic [TMR_W-1:0]  tmr;
    logic [IDX_W-1:0]  rr_ptr;

    logic [N_PROC-1:0] free;
    logic [IDX_W-1:0]  sel_idx;
    logic              accept;
    logic              ack_hit;
    logic              timeout_hit;
    logic              idle_nxt;

    logic [N_PROC-1:0] eligible;
    logic [N_PROC-1:0] grant_nxt;
    logic [IDX_W-1:0]  ptr_nxt;
    logic [IDX_W-1:0]  pos;
    logic              found;

    logic [SUM_W-1:0]  fin_cnt;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  net;
    logic [CNT_W-1:0]  inflight_nxt;

    // A processor already acking this cycle is not offered new work.
    assign free          = ~i_pool_busy & ~i_proc_mask & ~i_pool_ack;
    assign o_instr_ready = (state == ST_IDLE) && (|free) && !i_rst;
    assign accept        = i_instr_valid && o_instr_ready;
    // Only the target's ack counts; acks from other processors are ignored.
    assign ack_hit       = (state == ST_ISSUE) && i_pool_ack[tgt];
    assign timeout_hit   = (state == ST_ISSUE) && !ack_hit && (tmr == TMR_LAST);
    assign idle_nxt      = (state == ST_IDLE) ? !accept : (ack_hit || timeout_hit);

    // Pick the lowest-index free processor as dispatch target.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
        sel_idx = '0;
        for (int k = N_PROC - 1; k >= 0; k--) begin
            if (free[k]) sel_idx = IDX_W'(k);
        end
    end

    // Locked round-robin: keep an eligible holder, otherwise search from rr_ptr.
    always_comb begin
        eligible  = i_pool_req & ~i_proc_mask;
        grant_nxt = '0;
        ptr_nxt   = rr_ptr;
        found     = 1'b0;
        pos       = '0;
        if (|(o_pool_grant & eligible)) begin
            grant_nxt = o_pool_grant;
        end else begin
            for (int off = 0; off < N_PROC; off++) begin
                pos = IDX_W'((int'(rr_ptr) + off) % N_PROC);
                if (!found && eligible[pos]) begin
                    found          = 1'b1;
                    grant_nxt[pos] = 1'b1;
                    ptr_nxt        = IDX_W'((int'(pos) + 1) % N_PROC);
                end
            end
        end
    end

    // Net in-flight update: +1 on target ack, -popcount(finish), clamped to [0, max].
    always_comb begin
        fin_cnt = '0;
        for (int k = 0; k < N_PROC; k++) begin
            fin_cnt = fin_cnt + SUM_W'(i_pool_finish[k]);
        end
        sum = SUM_W'(o_inflight) + SUM_W'(ack_hit);
        net = sum - fin_cnt;
        if (sum < fin_cnt) begin
            inflight_nxt = '0;
        end else if (net > CNT_MAX) begin
            inflight_nxt = '1;
        end else begin
            inflight_nxt = CNT_W'(net);
        end
    end

    // Dispatch FSM: latch the accepted instruction and hold valid until ack or timeout.
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
        if (i_rst) begin
            state        <= ST_IDLE;
            tgt          <= '0;
            tmr          <= '0;
            o_pool_valid <= '0;
            o_err        <= 1'b0;
            // NOTE: the per-processor instruction registers are visible outputs, so they are reset rather than left as uninitialised storage.
            o_pool_instr <= '0;
        end else begin
            o_err <= timeout_hit;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state                 <= ST_ISSUE;
                        tgt                   <= sel_idx;
                        tmr                   <= '0;
                        o_pool_valid          <= N_PROC'(1) << sel_idx;
                        o_pool_instr[sel_idx] <= i_instr;
                    end
                end
                ST_ISSUE: begin
                    if (ack_hit || timeout_hit) begin
                        state        <= ST_IDLE;
                        tmr          <= '0;
                        o_pool_valid <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered one-hot grant and round-robin start pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pool_grant <= '0;
            rr_ptr       <= '0;
        end else begin
            o_pool_grant <= grant_nxt;
            rr_ptr       <= ptr_nxt;
        end
    end

    // Status outputs: enables, done echo, in-flight count and idle flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pool_en  <= '0;
            o_done     <= '0;
            o_inflight <= '0;
            o_idle     <= 1'b1;
        end else begin
            o_pool_en  <= ~i_proc_mask;
            o_done     <= i_pool_finish;
            o_inflight <= inflight_nxt;
            o_idle     <= (inflight_nxt == '0) && idle_nxt;
        end
    end

endmodule
